// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer and the control unit.
// Holds ALUOP encodings, the FSM state enum and the iteration count.
// Helper functions classify opcodes by kind and operand signedness.
package muldiv_sequencer_pkg;

    localparam logic [4:0] ALUOP_MUL    = 5'b01011;
    localparam logic [4:0] ALUOP_MULH   = 5'b01100;
    localparam logic [4:0] ALUOP_MULHSU = 5'b01101;
    localparam logic [4:0] ALUOP_MULHU  = 5'b01110;
    localparam logic [4:0] ALUOP_DIV    = 5'b01111;
    localparam logic [4:0] ALUOP_DIVU   = 5'b10000;
    localparam logic [4:0] ALUOP_REM    = 5'b10001;
    localparam logic [4:0] ALUOP_REMU   = 5'b10010;

    // One datapath iteration per operand bit
    localparam int unsigned ITER_COUNT = 32;
    localparam int          CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // MDU codes occupy one contiguous range
    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= ALUOP_DIV) && (op <= ALUOP_REMU);
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op1_signed(input logic [4:0] op);
        return (op == ALUOP_MULH) || (op == ALUOP_MULHSU) ||
               (op == ALUOP_DIV)  || (op == ALUOP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op2_signed(input logic [4:0] op);
        return (op == ALUOP_MULH) || (op == ALUOP_DIV) || (op == ALUOP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring divide on magnitudes.
// Latency: purely combinational; the sequencer registers the outputs each cycle.
// Backpressure: none; the sequencer decides when an iteration is committed.
module muldiv_iter_core (
    input  logic        is_div_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] diff;

    // Multiply: {hi,lo} accumulates the product while lo shifts the multiplier out.
    // Divide: {hi,lo} shifts left, hi is the partial remainder, lo collects quotient bits.
    always_comb begin
        sum    = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : 32'd0)};
        rem_sh = {hi_i, lo_i[31]};
        ge     = (rem_sh >= {1'b0, b_i});
        // When ge holds the true difference is below b_i, so 32 bits are exact
        diff   = rem_sh[31:0] - b_i;
        if (is_div_i) begin
            hi_o = ge ? diff : rem_sh[31:0];
            lo_o = {lo_i[30:0], ge};
        end else begin
            hi_o = sum[32:1];
            lo_o = {sum[0], lo_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences 32-bit RISC-V multiply/divide: latch, 32 bit-serial iterations, sign fix, result.
// Latency: fixed 34 cycles from the accepting edge to the VALID cycle, independent of operands.
// Backpressure: STALL freezes the front end from the issuing cycle until the result is ready.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [4:0]  ALUOP,
    input  logic [31:0] OPERAND1,
    input  logic [31:0] OPERAND2,
    input  logic        FLUSH,
    output logic [31:0] RESULT,
    output logic        VALID,
    output logic        BUSY,
    output logic        STALL
);

    state_e             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        bmag_q, bmag_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               last_iter;
    logic               core_is_div;
    logic [31:0]        core_hi, core_lo;
    logic [31:0]        a_mag_in, b_mag_in;
    logic [31:0]        fix_result;

    // FLUSH wins over START; only MDU codes in IDLE are taken
    assign accept      = (state_q == ST_IDLE) && START && !FLUSH && is_mdu_op(ALUOP);
    assign last_iter   = (cnt_q == CNT_W'(ITER_COUNT - 1));
    assign core_is_div = is_div_op(op_q);
    assign RESULT      = result_q;

    muldiv_iter_core u_core (
        .is_div_i (core_is_div),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (bmag_q),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: any FLUSH outside IDLE abandons the operation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)         state_d = ST_CALC;
            ST_CALC: if (FLUSH)          state_d = ST_IDLE;
                     else if (last_iter) state_d = ST_FIX;
            ST_FIX:  if (FLUSH)          state_d = ST_IDLE;
                     else                state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the IDLE stall term holds the issuing instruction from its first cycle
    always_comb begin
        BUSY  = (state_q != ST_IDLE);
        STALL = (RESET_N && accept) || (state_q == ST_CALC) || (state_q == ST_FIX);
        VALID = (state_q == ST_DONE) && !FLUSH;
    end

    // Operand magnitudes for the unsigned iteration core
    always_comb begin
        a_mag_in = (op1_signed(ALUOP) && OPERAND1[31]) ? -OPERAND1 : OPERAND1;
        b_mag_in = (op2_signed(ALUOP) && OPERAND2[31]) ? -OPERAND2 : OPERAND2;
    end

    // Sign correction, result selection and the divide corner cases
    always_comb begin
        logic        a_neg, b_neg, div_zero, ovf;
        logic [63:0] prod, prod_s;
        logic [31:0] quot_s, rem_s;
        a_neg    = op1_signed(op_q) && a_q[31];
        b_neg    = op2_signed(op_q) && b_q[31];
        div_zero = (b_q == 32'd0);
        ovf      = op2_signed(op_q) && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        prod     = {hi_q, lo_q};
        prod_s   = (a_neg ^ b_neg) ? -prod : prod;
        quot_s   = (a_neg ^ b_neg) ? -lo_q : lo_q;
        rem_s    = a_neg ? -hi_q : hi_q;
        fix_result = 32'd0;
        case (op_q)
            ALUOP_MUL:                             fix_result = prod_s[31:0];
            ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU: fix_result = prod_s[63:32];
            ALUOP_DIV, ALUOP_DIVU:
                fix_result = div_zero ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quot_s);
            ALUOP_REM, ALUOP_REMU:
                fix_result = div_zero ? a_q : (ovf ? 32'd0 : rem_s);
            default:                               fix_result = 32'd0;
        endcase
    end

    // Datapath next-state: latch on accept, iterate in CALC, publish leaving FIX
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        bmag_d   = bmag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            op_d   = ALUOP;
            a_d    = OPERAND1;
            b_d    = OPERAND2;
            bmag_d = b_mag_in;
            hi_d   = 32'd0;
            lo_d   = a_mag_in;
            cnt_d  = '0;
        end else if (state_q == ST_CALC) begin
            hi_d  = core_hi;
            lo_d  = core_lo;
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_FIX) && !FLUSH) begin
            result_d = fix_result;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bmag_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bmag_q   <= bmag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus randomized operations.
// A timeline/arithmetic model predicts every output each cycle.
// Directed results are also pinned to hand-computed literals.
module tb_muldiv_sequencer;

    localparam logic [4:0] OP_ADD    = 5'd1;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;
    localparam int         LATENCY   = 34;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        START = 1'b0;
    logic        FLUSH = 1'b0;
    logic [4:0]  ALUOP = 5'd0;
    logic [31:0] OPERAND1 = 32'd0;
    logic [31:0] OPERAND2 = 32'd0;
    logic [31:0] RESULT;
    logic        VALID, BUSY, STALL;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    muldiv_sequencer dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .ALUOP    (ALUOP),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .FLUSH    (FLUSH),
        .RESULT   (RESULT),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .STALL    (STALL)
    );

    function automatic logic is_mdu(input logic [4:0] op);
        return (op >= 5'd11) && (op <= 5'd18);
    endfunction

    // Architectural result computed with wide integer arithmetic
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MUL:    begin up = ua * ub; return up[31:0]; end
            OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
            OP_MULHSU: begin sp = sa * longint'(ub); return sp[63:32]; end
            OP_MULHU:  begin up = ua * ub; return up[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb; return sp[31:0];
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            OP_REMU: begin
                if (b == 32'd0) return a;
                up = ua % ub; return up[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // Timeline model: age counts edges since acceptance, -1 when idle; result lands at age 33
    int          age = -1;
    logic [31:0] pend_res = 32'd0;
    logic [31:0] last_res = 32'd0;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            age      = -1;
            last_res = 32'd0;
        end else if (age >= 0) begin
            if (FLUSH || age == LATENCY - 1) begin
                age = -1;
            end else begin
                age++;
                if (age == LATENCY - 1) last_res = pend_res;
            end
        end else if (START && !FLUSH && is_mdu(ALUOP)) begin
            age      = 0;
            pend_res = ref_result(ALUOP, OPERAND1, OPERAND2);
        end
    end

    logic exp_valid, exp_busy, exp_stall;

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (cmp_en) begin
            exp_busy  = (age >= 0);
            exp_valid = (age == LATENCY - 1) && !FLUSH;
            exp_stall = RESET_N && (((age < 0) && START && is_mdu(ALUOP) && !FLUSH) ||
                                    ((age >= 0) && (age < LATENCY - 1)));
            n_checks++;
            if (RESULT !== last_res || VALID !== exp_valid || BUSY !== exp_busy ||
                STALL !== exp_stall) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t: got RESULT=%h VALID=%b BUSY=%b STALL=%b, expected %h %b %b %b",
                         $time, RESULT, VALID, BUSY, STALL, last_res, exp_valid, exp_busy, exp_stall);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        START    = 1'b1;
        ALUOP    = op;
        OPERAND1 = a;
        OPERAND2 = b;
    endtask

    // Returns the negedge index (1 = first cycle after acceptance) on which VALID appears
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (VALID === 1'b1) begin
                lat = i;
                break;
            end
            #1 START = 1'b0;
        end
        START = 1'b0;
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: got no VALID within 40 cycles, expected one at %0d", LATENCY);
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int lat;
        check32({name, "_model"}, ref_result(op, a, b), exp);
        @(negedge CLK);
        #1 start_op(op, a, b);
        wait_valid(lat);
        check32({name, "_latency"}, 32'(lat), 32'(LATENCY));
        check32({name, "_result"}, RESULT, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 15);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2000000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          flush_at;
        int          gap;
        logic        saw_valid;
        logic [4:0]  op;
        logic [31:0] a, b;

        #1 RESET_N = 1'b0;
        cmp_en = 1'b1;

        // Reset state, with an MDU request pending that must not raise STALL
        @(negedge CLK);
        #1 start_op(OP_MUL, 32'd7, 32'd3);
        @(negedge CLK);
        check32("rst_result", RESULT, 32'd0);
        check32("rst_valid", 32'(VALID), 32'd0);
        check32("rst_busy", 32'(BUSY), 32'd0);
        check32("rst_stall", 32'(STALL), 32'd0);
        #1 START = 1'b0;
        RESET_N = 1'b1;

        // Directed arithmetic corner cases
        run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_x_m3");
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1");
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2");
        run_op(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(OP_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "rem_by_zero");
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");

        // Flush mid-divide, then a MUL issued the following cycle
        @(negedge CLK);
        #1 start_op(OP_DIVU, 32'd1000, 32'd3);
        saw_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (VALID === 1'b1) saw_valid = 1'b1;
            #1 START = 1'b0;
            if (i == 10) FLUSH = 1'b1;
        end
        @(negedge CLK);
        check32("flush_busy", 32'(BUSY), 32'd0);
        check32("flush_no_valid", 32'(saw_valid), 32'd0);
        check32("flush_result_kept", RESULT, 32'hFFFF_FFFF);
        #1 FLUSH = 1'b0;
        start_op(OP_MUL, 32'd12345, 32'd678);
        wait_valid(lat);
        check32("post_flush_latency", 32'(lat), 32'(LATENCY));
        check32("post_flush_result", RESULT, 32'd8369910);

        // Non-MDU START is ignored
        @(negedge CLK);
        #1 start_op(OP_ADD, 32'd1, 32'd2);
        @(negedge CLK);
        check32("add_busy", 32'(BUSY), 32'd0);
        check32("add_stall", 32'(STALL), 32'd0);
        #1 START = 1'b0;

        // START during CALC is ignored and leaves the running operation intact
        @(negedge CLK);
        #1 start_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (VALID === 1'b1) begin
                lat = i;
                break;
            end
            #1;
            if (i == 5) start_op(OP_DIV, 32'd99, 32'd4);
            else START = 1'b0;
        end
        START = 1'b0;
        check32("busy_start_latency", 32'(lat), 32'(LATENCY));
        check32("busy_start_result", RESULT, 32'hFFFF_FFEB);

        // Asynchronous reset mid-CALC, then a fresh divide right after release
        @(negedge CLK);
        #1 start_op(OP_DIVU, 32'd50000, 32'd3);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            #1 START = 1'b0;
        end
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check32("arst_result", RESULT, 32'd0);
        check32("arst_valid", 32'(VALID), 32'd0);
        check32("arst_busy", 32'(BUSY), 32'd0);
        check32("arst_stall", 32'(STALL), 32'd0);
        @(negedge CLK);
        #1 RESET_N = 1'b1;
        check32("divu_100_7_model", ref_result(OP_DIVU, 32'd100, 32'd7), 32'h0000_000E);
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        check32("after_rst_latency", 32'(lat), 32'(LATENCY));
        check32("after_rst_result", RESULT, 32'h0000_000E);

        // Randomized operations with idle gaps, stray non-MDU STARTs and occasional flushes
        for (int n = 0; n < 150; n++) begin
            op       = 5'(11 + $urandom_range(0, 7));
            a        = pick();
            b        = pick();
            flush_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : 0;
            gap      = $urandom_range(0, 2);
            repeat (gap) begin
                int v;
                @(negedge CLK);
                v = $urandom_range(0, 23);
                #1 START = 1'($urandom_range(0, 1));
                ALUOP = (v < 11) ? 5'(v) : 5'(v + 8);
            end
            @(negedge CLK);
            #1 start_op(op, a, b);
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge CLK);
                if (VALID === 1'b1) begin
                    lat = i;
                    break;
                end
                #1 START = 1'b0;
                if (flush_at != 0 && i == flush_at + 1) begin
                    FLUSH = 1'b0;
                    break;
                end
                if (i == flush_at) FLUSH = 1'b1;
            end
            START = 1'b0;
            if (flush_at != 0) begin
                check32("rand_flush_no_valid", 32'(lat), 32'd0);
            end else if (lat == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_timeout: got no VALID for op %0d, expected one at %0d", op, LATENCY);
            end else begin
                check32("rand_latency", 32'(lat), 32'(LATENCY));
                check32("rand_result", RESULT, ref_result(op, a, b));
            end
        end

        repeat (3) @(negedge CLK);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
